// File: rtl/top_memory_access.sv
// Memory-access stage: forwards execute results to write-back, runs loads/stores over a req/ack bus.
// Latency 1 cycle for non-bus ops, 2+ cycles for bus ops; stall_memory holds the pipeline while a transfer is pending.
module top_memory_access #(
  parameter int XLEN      = 32,
  parameter int OPLEN     = 16,
  parameter int LOAD_BIT  = 0,
  parameter int STORE_BIT = 1,
  parameter int F3_LSB    = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             phase_memory,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic             jump_state_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic             jump_state_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic [XLEN-1:0]  rd_data_mw,
  output logic             misalign_mw,
  output logic             err_mw,
  output logic             stall_memory
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [OPLEN-1:0] op_q;
  logic [4:0]       rdsel_q;
  logic [XLEN-1:0]  npc_q;
  logic [XLEN-1:0]  alu_q;
  logic             jmp_q;

  logic             is_ld, memop, illegal, misal, start, acc, timeout_hit;
  logic [2:0]       f3;
  logic [1:0]       a_lo;
  logic [3:0]       be_n;
  logic [XLEN-1:0]  wdata_n;
  logic [XLEN-1:0]  ld_sh, ld_ext;
  logic             lat_vld, lat_err, lat_mis;
  logic [XLEN-1:0]  lat_rd;
  logic [OPLEN-1:0] src_op;
  logic [4:0]       src_rdsel;
  logic [XLEN-1:0]  src_npc, src_alu;
  logic             src_jmp;

  assign is_ld   = decoded_op_em[LOAD_BIT];
  assign memop   = decoded_op_em[LOAD_BIT] | decoded_op_em[STORE_BIT];
  assign f3      = decoded_op_em[F3_LSB +: 3];
  assign a_lo    = alu_out_em[1:0];
  // Loads allow LB/LH/LW/LBU/LHU; stores only SB/SH/SW.
  assign illegal = is_ld ? (f3 == 3'b011 || f3[2:1] == 2'b11) : (f3 > 3'b010);
  assign misal   = (f3[1:0] == 2'b01 && a_lo[0]) || (f3[1:0] == 2'b10 && a_lo != 2'b00);
  assign acc     = (state_q == ACCESS);
  assign start   = !acc && phase_memory && memop && !illegal && !misal;
  assign timeout_hit = (cnt_q == CNT_LAST);

  assign stall_memory = rst_n && (acc ? !(dmem_ack || timeout_hit) : start);

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = rs2data_em;
    case (f3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << a_lo;
        wdata_n = {4{rs2data_em[7:0]}};
      end
      2'b01: begin
        be_n    = a_lo[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{rs2data_em[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_sh = dmem_rdata >> {alu_q[1:0], 3'b000};
    case (op_q[F3_LSB +: 3])
      3'b000:  ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_ext = {24'd0, ld_sh[7:0]};
      3'b101:  ld_ext = {16'd0, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // Bus ops latch from the copy captured at request time, so upstream need not hold inputs.
  assign src_op    = acc ? op_q    : decoded_op_em;
  assign src_rdsel = acc ? rdsel_q : rdsel_em;
  assign src_npc   = acc ? npc_q   : next_pc_em;
  assign src_alu   = acc ? alu_q   : alu_out_em;
  assign src_jmp   = acc ? jmp_q   : jump_state_em;

  always_comb begin
    lat_vld = 1'b0;
    lat_rd  = '0;
    lat_err = 1'b0;
    lat_mis = 1'b0;
    if (!acc) begin
      if (phase_memory) begin
        if (!memop) begin
          lat_vld = 1'b1;
          lat_rd  = alu_out_em;
        end else if (illegal) begin
          lat_vld = 1'b1;
          lat_err = 1'b1;
        end else if (misal) begin
          lat_vld = 1'b1;
          lat_mis = 1'b1;
        end
      end
    end else if (dmem_ack) begin
      lat_vld = 1'b1;
      lat_rd  = op_q[LOAD_BIT] ? ld_ext : alu_q;
    end else if (timeout_hit) begin
      lat_vld = 1'b1;
      lat_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      rdsel_q       <= '0;
      npc_q         <= '0;
      alu_q         <= '0;
      jmp_q         <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= '0;
      dmem_wdata    <= '0;
      decoded_op_mw <= '0;
      rdsel_mw      <= '0;
      next_pc_mw    <= '0;
      jump_state_mw <= 1'b0;
      alu_out_mw    <= '0;
      rd_data_mw    <= '0;
      misalign_mw   <= 1'b0;
      err_mw        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= !is_ld;
            dmem_addr  <= {alu_out_em[XLEN-1:2], 2'b00};
            dmem_be    <= be_n;
            dmem_wdata <= wdata_n;
            cnt_q      <= '0;
            op_q       <= decoded_op_em;
            rdsel_q    <= rdsel_em;
            npc_q      <= next_pc_em;
            alu_q      <= alu_out_em;
            jmp_q      <= jump_state_em;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack || timeout_hit) begin
            dmem_req <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
      if (lat_vld) begin
        decoded_op_mw <= src_op;
        rdsel_mw      <= src_rdsel;
        next_pc_mw    <= src_npc;
        jump_state_mw <= src_jmp;
        alu_out_mw    <= src_alu;
        rd_data_mw    <= lat_rd;
        err_mw        <= lat_err;
        misalign_mw   <= lat_mis;
      end
    end
  end

endmodule

// File: tb/tb_top_memory_access.sv
// Bench for top_memory_access: directed scenarios plus randomized ops against a behavioural model.
module tb_top_memory_access;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        phase_memory = 1'b0;
  logic [15:0] decoded_op_em = '0;
  logic [31:0] alu_out_em = '0;
  logic [31:0] rs2data_em = '0;
  logic [4:0]  rdsel_em = '0;
  logic [31:0] next_pc_em = '0;
  logic        jump_state_em = 1'b0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [15:0] decoded_op_mw;
  logic [4:0]  rdsel_mw;
  logic [31:0] next_pc_mw, alu_out_mw, rd_data_mw;
  logic        jump_state_mw, misalign_mw, err_mw, stall_memory;

  int total = 0;
  int bad   = 0;

  top_memory_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .phase_memory(phase_memory),
    .decoded_op_em(decoded_op_em), .alu_out_em(alu_out_em), .rs2data_em(rs2data_em),
    .rdsel_em(rdsel_em), .next_pc_em(next_pc_em), .jump_state_em(jump_state_em),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .decoded_op_mw(decoded_op_mw), .rdsel_mw(rdsel_mw), .next_pc_mw(next_pc_mw),
    .jump_state_mw(jump_state_mw), .alu_out_mw(alu_out_mw), .rd_data_mw(rd_data_mw),
    .misalign_mw(misalign_mw), .err_mw(err_mw), .stall_memory(stall_memory)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done;
    int          stalls;
    int          reqcyc;
    int          unstable;
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    logic        mis;
    logic [15:0] op;
    logic [4:0]  rdsel;
    logic [31:0] npc;
    logic [31:0] alu;
    logic        jmp;
  } obs_t;

  // Op encoding used by the default DUT parameters: bit0 load, bit1 store, bits[4:2] funct3.
  function automatic logic [15:0] mkop(input bit ld, input bit st, input logic [2:0] f3v);
    logic [10:0] hi;
    hi = 11'($urandom);
    return {hi, f3v, st, ld};
  endfunction

  task automatic set_inputs(input logic [15:0] opv, input logic [31:0] alu_v, input logic [31:0] rs2_v);
    decoded_op_em = opv;
    alu_out_em    = alu_v;
    rs2data_em    = rs2_v;
    rdsel_em      = 5'($urandom);
    next_pc_em    = $urandom;
    jump_state_em = 1'($urandom);
  endtask

  // Reference: what one op should produce, given when the bus acks (-1 = never).
  function automatic obs_t model(input int ack_delay, input logic [31:0] rdata);
    obs_t e;
    int f3v, n, a;
    bit ld, st, legal, acked;
    longint unsigned v, mask;
    ld = decoded_op_em[0];
    st = decoded_op_em[1];
    f3v = int'(decoded_op_em[4:2]);
    a = int'(alu_out_em % 4);
    n = 1 << (f3v % 4);
    e.done = 1; e.stalls = 0; e.reqcyc = 0; e.unstable = 0;
    e.be = '0; e.we = 1'b0; e.addr = '0; e.wdata = '0;
    e.op = decoded_op_em; e.rdsel = rdsel_em; e.npc = next_pc_em; e.alu = alu_out_em;
    e.jmp = jump_state_em; e.err = 1'b0; e.mis = 1'b0; e.rd = alu_out_em;
    if (ld || st) begin
      legal = ld ? (f3v inside {0, 1, 2, 4, 5}) : (f3v <= 2);
      if (!legal) begin
        e.err = 1'b1; e.rd = '0;
      end else if (a % n != 0) begin
        e.mis = 1'b1; e.rd = '0;
      end else begin
        acked = (ack_delay >= 0) && (ack_delay < TO);
        e.reqcyc = acked ? ack_delay + 1 : TO;
        e.stalls = acked ? ack_delay + 1 : TO;
        e.we = !ld;
        e.addr = alu_out_em - 32'(a);
        e.be = 4'(((1 << n) - 1) << a);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = rs2data_em[8*(i % n) +: 8];
        if (!acked) begin
          e.err = 1'b1; e.rd = '0;
        end else if (ld) begin
          mask = (64'd1 << (8 * n)) - 1;
          v = (longint'(rdata) >> (8 * a)) & mask;
          if (f3v < 4 && v[8*n-1]) v = v | ~mask;
          e.rd = v[31:0];
        end
      end
    end
    return e;
  endfunction

  // Drives one op (inputs already set) and plays the bus; b2b skips the leading idle cycle.
  task automatic run_txn(input int ack_delay, input logic [31:0] rdata, input bit b2b, output obs_t o);
    o.done = 0; o.stalls = 0; o.reqcyc = 0; o.unstable = 0;
    o.be = '0; o.we = 1'b0; o.addr = '0; o.wdata = '0;
    if (!b2b) @(negedge clk);
    phase_memory = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c > 0 && !dmem_req) begin
        o.done = 1;
        break;
      end
      if (dmem_req) begin
        if (o.reqcyc == 0) begin
          o.be = dmem_be; o.we = dmem_we; o.addr = dmem_addr; o.wdata = dmem_wdata;
        end else if (dmem_be !== o.be || dmem_we !== o.we || dmem_addr !== o.addr || dmem_wdata !== o.wdata) begin
          o.unstable++;
        end
        dmem_ack = (ack_delay >= 0 && o.reqcyc == ack_delay);
        dmem_rdata = rdata;
        o.reqcyc++;
      end else begin
        dmem_ack = 1'($urandom);
        dmem_rdata = $urandom;
      end
      #1;
      if (stall_memory) o.stalls++;
      @(negedge clk);
    end
    phase_memory = 1'b0;
    dmem_ack = 1'b0;
    o.rd = rd_data_mw; o.err = err_mw; o.mis = misalign_mw; o.op = decoded_op_mw;
    o.rdsel = rdsel_mw; o.npc = next_pc_mw; o.alu = alu_out_mw; o.jmp = jump_state_mw;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
      bad++; $display("FAIL reset_bus: got %h want 0", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata});
    end
    total++;
    if ({decoded_op_mw, rdsel_mw, next_pc_mw, jump_state_mw, alu_out_mw, rd_data_mw, misalign_mw, err_mw} !== '0) begin
      bad++; $display("FAIL reset_mw: got %h want 0", {decoded_op_mw, rdsel_mw, next_pc_mw, alu_out_mw, rd_data_mw});
    end
    total++;
    if (stall_memory !== 1'b0) begin
      bad++; $display("FAIL reset_stall: got %b want 0", stall_memory);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nonmem();
    obs_t o;
    set_inputs(mkop(0, 0, 3'($urandom)), 32'h0000_1234, $urandom);
    run_txn(0, '0, 0, o);
    total++;
    if (o.rd !== 32'h1234 || o.err !== 1'b0 || o.mis !== 1'b0) begin
      bad++; $display("FAIL nonmem_rd: got rd=%h err=%b mis=%b want rd=00001234 err=0 mis=0", o.rd, o.err, o.mis);
    end
    total++;
    if (o.stalls !== 0 || o.reqcyc !== 0 || !o.done) begin
      bad++; $display("FAIL nonmem_stall: got stalls=%0d req=%0d done=%0d want 0 0 1", o.stalls, o.reqcyc, o.done);
    end
    total++;
    if (o.op !== decoded_op_em || o.rdsel !== rdsel_em || o.npc !== next_pc_em || o.jmp !== jump_state_em || o.alu !== 32'h1234) begin
      bad++; $display("FAIL nonmem_fwd: got op=%h rd=%h pc=%h want op=%h rd=%h pc=%h", o.op, o.rdsel, o.npc, decoded_op_em, rdsel_em, next_pc_em);
    end
  endtask

  task automatic test_lb();
    obs_t o;
    set_inputs(mkop(1, 0, 3'b000), 32'h0000_0103, $urandom);
    run_txn(3, 32'h80FF_FFFF, 0, o);
    total++;
    if (o.be !== 4'b1000 || o.we !== 1'b0 || o.addr !== 32'h100) begin
      bad++; $display("FAIL lb_bus: got be=%b we=%b addr=%h want 1000 0 00000100", o.be, o.we, o.addr);
    end
    total++;
    if (o.rd !== 32'hFFFF_FF80 || o.err !== 1'b0) begin
      bad++; $display("FAIL lb_data: got %h err=%b want ffffff80 err=0", o.rd, o.err);
    end
    total++;
    if (o.stalls !== 4 || o.reqcyc !== 4) begin
      bad++; $display("FAIL lb_stall: got stalls=%0d req=%0d want 4 4", o.stalls, o.reqcyc);
    end
  endtask

  task automatic test_sh_misalign();
    obs_t o;
    set_inputs(mkop(0, 1, 3'b001), 32'h0000_0102, 32'hABCD_1234);
    run_txn(0, '0, 0, o);
    total++;
    if (o.be !== 4'b1100 || o.wdata !== 32'h1234_1234 || o.we !== 1'b1 || o.unstable !== 0) begin
      bad++; $display("FAIL sh_bus: got be=%b wdata=%h we=%b want 1100 12341234 1", o.be, o.wdata, o.we);
    end
    total++;
    if (o.stalls !== 1 || o.rd !== 32'h102) begin
      bad++; $display("FAIL sh_done: got stalls=%0d rd=%h want 1 00000102", o.stalls, o.rd);
    end
    set_inputs(mkop(1, 0, 3'b010), 32'h0000_0101, $urandom);
    run_txn(0, '0, 0, o);
    total++;
    if (o.mis !== 1'b1 || o.err !== 1'b0 || o.rd !== 32'h0 || o.reqcyc !== 0 || o.stalls !== 0) begin
      bad++; $display("FAIL lw_misalign: got mis=%b err=%b rd=%h req=%0d stalls=%0d want 1 0 0 0 0", o.mis, o.err, o.rd, o.reqcyc, o.stalls);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    set_inputs(mkop(1, 0, 3'b010), 32'h0000_0200, $urandom);
    run_txn(-1, 32'h5555_AAAA, 0, o);
    total++;
    if (o.reqcyc !== TO || o.stalls !== TO || !o.done) begin
      bad++; $display("FAIL timeout_len: got req=%0d stalls=%0d want %0d %0d", o.reqcyc, o.stalls, TO, TO);
    end
    total++;
    if (o.err !== 1'b1 || o.rd !== 32'h0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL timeout_err: got err=%b rd=%h req=%b want 1 0 0", o.err, o.rd, dmem_req);
    end
    set_inputs(mkop(1, 0, 3'b010), 32'h0000_0204, $urandom);
    run_txn(TO - 1, 32'h5555_AAAA, 0, o);
    total++;
    if (o.err !== 1'b0 || o.rd !== 32'h5555_AAAA || o.reqcyc !== TO) begin
      bad++; $display("FAIL ack_at_limit: got err=%b rd=%h req=%0d want 0 5555aaaa %0d", o.err, o.rd, o.reqcyc, TO);
    end
  endtask

  task automatic test_lbu_illegal();
    obs_t o;
    set_inputs(mkop(1, 0, 3'b100), 32'h0000_0001, $urandom);
    run_txn(1, 32'h0000_9A00, 0, o);
    total++;
    if (o.rd !== 32'h0000_009A || o.be !== 4'b0010) begin
      bad++; $display("FAIL lbu_data: got rd=%h be=%b want 0000009a 0010", o.rd, o.be);
    end
    set_inputs(mkop(1, 0, 3'b011), 32'h0000_0040, $urandom);
    run_txn(0, '0, 0, o);
    total++;
    if (o.err !== 1'b1 || o.reqcyc !== 0 || o.rd !== 32'h0 || o.stalls !== 0) begin
      bad++; $display("FAIL ld_f3_011: got err=%b req=%0d rd=%h stalls=%0d want 1 0 0 0", o.err, o.reqcyc, o.rd, o.stalls);
    end
    set_inputs(mkop(0, 1, 3'b100), 32'h0000_0040, $urandom);
    run_txn(0, '0, 0, o);
    total++;
    if (o.err !== 1'b1 || o.reqcyc !== 0) begin
      bad++; $display("FAIL st_f3_100: got err=%b req=%0d want 1 0", o.err, o.reqcyc);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    int cls, dly, r;
    logic [2:0] f3v;
    logic [31:0] rdata;
    for (int it = 0; it < 40; it++) begin
      cls = $urandom_range(0, 2);
      f3v = 3'($urandom);
      if ($urandom_range(0, 3) != 0) f3v = (cls == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) + ($urandom_range(0, 1) * 4));
      if (f3v == 3'b110) f3v = 3'b100;
      set_inputs(mkop(cls == 1, cls == 2, f3v), $urandom, $urandom);
      r = $urandom_range(0, 9);
      dly = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TO - 1 : (r == 8) ? -1 : TO - 2;
      rdata = $urandom;
      e = model(dly, rdata);
      run_txn(dly, rdata, 0, o);
      total++;
      if (!o.done || o.stalls !== e.stalls || o.reqcyc !== e.reqcyc || o.unstable !== 0) begin
        bad++; $display("FAIL rnd%0d_timing: got done=%0d stalls=%0d req=%0d unstable=%0d want stalls=%0d req=%0d", it, o.done, o.stalls, o.reqcyc, o.unstable, e.stalls, e.reqcyc);
      end
      total++;
      if (o.rd !== e.rd || o.err !== e.err || o.mis !== e.mis) begin
        bad++; $display("FAIL rnd%0d_result: got rd=%h err=%b mis=%b want rd=%h err=%b mis=%b", it, o.rd, o.err, o.mis, e.rd, e.err, e.mis);
      end
      total++;
      if (o.op !== e.op || o.rdsel !== e.rdsel || o.npc !== e.npc || o.alu !== e.alu || o.jmp !== e.jmp) begin
        bad++; $display("FAIL rnd%0d_fwd: got op=%h alu=%h pc=%h want op=%h alu=%h pc=%h", it, o.op, o.alu, o.npc, e.op, e.alu, e.npc);
      end
      if (e.reqcyc > 0) begin
        total++;
        if (o.be !== e.be || o.we !== e.we || o.addr !== e.addr || (e.we && o.wdata !== e.wdata)) begin
          bad++; $display("FAIL rnd%0d_bus: got be=%b we=%b addr=%h wd=%h want be=%b we=%b addr=%h wd=%h", it, o.be, o.we, o.addr, o.wdata, e.be, e.we, e.addr, e.wdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [31:0] rdata;
    for (int it = 0; it < 6; it++) begin
      case (it % 3)
        0:       set_inputs(mkop(1, 0, 3'b001), {$urandom} & 32'hFFFF_FFFE, $urandom);
        1:       set_inputs(mkop(0, 1, 3'b000), $urandom, $urandom);
        default: set_inputs(mkop(0, 0, 3'($urandom)), $urandom, $urandom);
      endcase
      rdata = $urandom;
      e = model(it % 2, rdata);
      run_txn(it % 2, rdata, it != 0, o);
      total++;
      if (o.rd !== e.rd || o.err !== e.err || o.stalls !== e.stalls || o.reqcyc !== e.reqcyc || o.alu !== e.alu) begin
        bad++; $display("FAIL b2b%0d: got rd=%h err=%b stalls=%0d req=%0d want rd=%h err=%b stalls=%0d req=%0d", it, o.rd, o.err, o.stalls, o.reqcyc, e.rd, e.err, e.stalls, e.reqcyc);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    set_inputs(mkop(0, 0, 3'b000), 32'hDEAD_BEEF, $urandom);
    run_txn(0, '0, 0, o);
    @(negedge clk);
    set_inputs(mkop(1, 0, 3'b010), 32'h0000_0100, $urandom);
    phase_memory = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (dmem_req !== 1'b1 || rd_data_mw !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL midrst_pre: got req=%b rd=%h want 1 deadbeef", dmem_req, rd_data_mw);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_memory !== 1'b0) begin
      bad++; $display("FAIL midrst_req: got req=%b stall=%b want 0 0", dmem_req, stall_memory);
    end
    total++;
    if ({decoded_op_mw, rdsel_mw, next_pc_mw, jump_state_mw, alu_out_mw, rd_data_mw, misalign_mw, err_mw} !== '0) begin
      bad++; $display("FAIL midrst_mw: got rd=%h alu=%h pc=%h want 0", rd_data_mw, alu_out_mw, next_pc_mw);
    end
    @(negedge clk);
    phase_memory = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_lb();
    test_sh_misalign();
    test_timeout();
    test_lbu_illegal();
    test_random();
    test_back_to_back();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
